// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - round-robin writeback arbiter with register busy scoreboard
//
// Shares the single register-file write port between NUM_SRC writeback
// producers and tracks in-flight destination registers for hazard stalls.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   src_valid/src_rd/src_data per-source writeback request, rd and data (packed)
//   src_ready                one-hot combinational grant
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   iss_valid/iss_has_rd     issue-stage dispatch and "writes a register"
//   iss_rd/iss_rs1/iss_rs2   issue-stage register indices
//   iss_stall                combinational hazard stall
//   busy_vec                 scoreboard state (bit 0 always 0)

module rf_writeback_arbiter #(
    parameter int NUM_SRC = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [5*NUM_SRC-1:0]    src_rd,
    input  logic [32*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]      src_ready,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    input  logic                    iss_valid,
    input  logic                    iss_has_rd,
    input  logic [4:0]              iss_rd,
    input  logic [4:0]              iss_rs1,
    input  logic [4:0]              iss_rs2,
    output logic                    iss_stall,
    output logic [31:0]             busy_vec
);

    localparam int PTR_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic [31:0]      busy_q, busy_d;

    logic             found;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   idx;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;
    logic             write_fire;
    logic             iss_set;

    // Round-robin search starting at rr_ptr; idx carries one extra bit so the
    // modulo wrap can be done by a single compare-and-subtract.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_SRC)) begin
                idx = idx - (PTR_W+1)'(NUM_SRC);
            end
            if (!found && src_valid[idx[PTR_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (found) begin
            src_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_rd   = src_rd[int'(grant_idx)*5 +: 5];
    assign sel_data = src_data[int'(grant_idx)*32 +: 32];

    // A grant to x0 consumes the slot but never reaches the register file.
    assign write_fire = found && (sel_rd != 5'd0);

    assign iss_stall = busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_has_rd & busy_q[iss_rd]);
    assign iss_set   = iss_valid & ~iss_stall & iss_has_rd & (iss_rd != 5'd0);

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rf_we_d    = write_fire;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        busy_d     = busy_q;

        if (found) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
        end
        if (write_fire) begin
            rf_waddr_d = sel_rd;
            rf_wdata_d = sel_data;
        end

        // Clear first so a same-edge set of the same register wins.
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - directed self-checking bench for rf_writeback_arbiter

module tb_rf_writeback_arbiter;

    localparam int NUM_SRC = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_SRC-1:0]    src_valid;
    logic [5*NUM_SRC-1:0]  src_rd;
    logic [32*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]    src_ready;
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [31:0]           rf_wdata;
    logic                  iss_valid;
    logic                  iss_has_rd;
    logic [4:0]            iss_rd;
    logic [4:0]            iss_rs1;
    logic [4:0]            iss_rs2;
    logic                  iss_stall;
    logic [31:0]           busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_writeback_arbiter #(.NUM_SRC(NUM_SRC)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_rd     (src_rd),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .iss_valid  (iss_valid),
        .iss_has_rd (iss_has_rd),
        .iss_rd     (iss_rd),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_stall  (iss_stall),
        .busy_vec   (busy_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here and
    // combinational outputs are sampled after a further #1 settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] data);
        src_rd[i*5 +: 5]    = rd;
        src_data[i*32 +: 32] = data;
    endtask

    initial begin
        rst        = 1'b1;
        src_valid  = 3'b111;
        src_rd     = '0;
        src_data   = '0;
        iss_valid  = 1'b0;
        iss_has_rd = 1'b0;
        iss_rd     = 5'd0;
        iss_rs1    = 5'd0;
        iss_rs2    = 5'd0;
        set_src(0, 5'd5, 32'h0000_00A0);
        set_src(1, 5'd6, 32'h0000_00B0);
        set_src(2, 5'd7, 32'h0000_00C0);

        // Reset with all sources requesting
        #2;
        check("rst_ready", 32'(src_ready), 32'h1);
        step();
        check("rst_we", 32'(rf_we), 32'h0);
        check("rst_busy", busy_vec, 32'h0);
        check("rst_waddr", 32'(rf_waddr), 32'h0);
        check("rst_wdata", rf_wdata, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_ptr_ready", 32'(src_ready), 32'h1);

        // Round-robin with all three valid: 5,6,7,5,6,7
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_ready", 32'(src_ready), 32'(1 << (i % 3)));
            step();
            check("rr_we", 32'(rf_we), 32'h1);
            check("rr_waddr", 32'(rf_waddr), 32'(5 + (i % 3)));
            check("rr_wdata", rf_wdata, 32'hA0 + 32'((i % 3) * 16));
        end
        src_valid = 3'b000;
        step();
        check("idle_we", 32'(rf_we), 32'h0);
        check("idle_waddr_hold", 32'(rf_waddr), 32'd7);

        // Single source 2
        src_valid = 3'b100;
        set_src(2, 5'd9, 32'hDEAD_BEEF);
        #1;
        check("single_ready", 32'(src_ready), 32'h4);
        step();
        src_valid = 3'b000;
        check("single_we", 32'(rf_we), 32'h1);
        check("single_waddr", 32'(rf_waddr), 32'd9);
        check("single_wdata", rf_wdata, 32'hDEAD_BEEF);

        // RAW hazard on x4
        iss_valid = 1'b1; iss_has_rd = 1'b1; iss_rd = 5'd4;
        #1;
        check("haz_issue_nostall", 32'(iss_stall), 32'h0);
        step();
        iss_valid = 1'b0; iss_has_rd = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd4;
        #1;
        check("haz_stall", 32'(iss_stall), 32'h1);
        check("haz_busy", busy_vec, 32'h0000_0010);
        src_valid = 3'b001;
        set_src(0, 5'd4, 32'h0000_0044);
        #1;
        check("haz_ready", 32'(src_ready), 32'h1);
        step();
        src_valid = 3'b000;
        #1;
        check("haz_we", 32'(rf_we), 32'h1);
        check("haz_waddr", 32'(rf_waddr), 32'd4);
        check("haz_stall_wecycle", 32'(iss_stall), 32'h1);
        step();
        check("haz_release", 32'(iss_stall), 32'h0);
        check("haz_busy_clear", busy_vec, 32'h0);
        iss_rs1 = 5'd0;

        // x0: issue and writeback to x0 (rr_ptr is 1 now)
        iss_valid = 1'b1; iss_has_rd = 1'b1; iss_rd = 5'd0;
        step();
        iss_valid = 1'b0; iss_has_rd = 1'b0;
        check("x0_busy_issue", busy_vec, 32'h0);
        src_valid = 3'b010;
        set_src(1, 5'd0, 32'h1234_5678);
        #1;
        check("x0_ready", 32'(src_ready), 32'h2);
        step();
        check("x0_we", 32'(rf_we), 32'h0);
        check("x0_busy_wb", busy_vec, 32'h0);
        set_src(0, 5'd5, 32'h0000_00A0);
        set_src(2, 5'd7, 32'h0000_00C0);
        src_valid = 3'b111;
        #1;
        check("x0_ptr_advanced", 32'(src_ready), 32'h4);
        step();
        src_valid = 3'b000;
        check("x0_next_waddr", 32'(rf_waddr), 32'd7);

        // Collision: write to x8 in the same cycle as an issue to x8 (rr_ptr is 0)
        src_valid = 3'b001;
        set_src(0, 5'd8, 32'h0000_0088);
        step();
        src_valid = 3'b000;
        iss_valid = 1'b1; iss_has_rd = 1'b1; iss_rd = 5'd8;
        #1;
        check("col_we", 32'(rf_we), 32'h1);
        check("col_waddr", 32'(rf_waddr), 32'd8);
        check("col_nostall", 32'(iss_stall), 32'h0);
        step();
        iss_valid = 1'b0; iss_has_rd = 1'b0; iss_rd = 5'd0;
        check("col_busy_set_wins", busy_vec, 32'h0000_0100);
        step();
        check("col_busy_holds", busy_vec, 32'h0000_0100);

        // Reset beats a grant and clears the scoreboard
        rst = 1'b1;
        src_valid = 3'b111;
        step();
        rst = 1'b0;
        src_valid = 3'b000;
        check("rst2_we", 32'(rf_we), 32'h0);
        check("rst2_busy", busy_vec, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Shares the register file's single write port between NUM_SRC writeback producers (e.g. ALU, load unit, mul/div) using round-robin arbitration with a valid/ready handshake. It tracks in-flight destination registers in a 32-entry busy scoreboard so the issue stage can stall on read-after-write and write-after-write hazards. It sits between the execute/memory stages and the register file write port. Its registered write outputs drive the register file's write-enable, write-address and write-data inputs directly.

## Interface
Parameters:
- NUM_SRC, 3, number of writeback requesters (2..8)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- src_valid  in  NUM_SRC  per-source writeback request
- src_rd  in  5*NUM_SRC  per-source destination register; source i at bits [5i+4:5i]
- src_data  in  32*NUM_SRC  per-source write data; source i at bits [32i+31:32i]
- src_ready  out  NUM_SRC  one-hot grant, combinational; transfer occurs when valid&&ready
- rf_we  out  1  register-file write enable, registered
- rf_waddr  out  5  register-file write address, registered
- rf_wdata  out  32  register-file write data, registered
- iss_valid  in  1  issue stage dispatches an instruction this cycle (qualified by !iss_stall)
- iss_has_rd  in  1  dispatched instruction writes a register
- iss_rd  in  5  destination of the dispatched instruction
- iss_rs1  in  5  source 1 of the instruction at issue
- iss_rs2  in  5  source 2 of the instruction at issue
- iss_stall  out  1  combinational; busy[iss_rs1] | busy[iss_rs2] | (iss_has_rd & busy[iss_rd])
- busy_vec  out  32  scoreboard state; bit 0 is always 0

## Operation
- Arbitration: rr_ptr (log2 NUM_SRC bits) marks the highest-priority source.
  - Search order: rr_ptr, rr_ptr+1, ... wrapping modulo NUM_SRC.
  - The first valid source found gets src_ready; at most one ready bit is high.
  - After a grant to source g, rr_ptr <= (g+1) mod NUM_SRC. With no grant, rr_ptr holds.
- Write generation: on a grant, next cycle rf_we=1, rf_waddr=src_rd[g], rf_wdata=src_data[g]. With no grant, rf_we=0 and rf_waddr/rf_wdata hold.
- x0 writes: a request to rd=0 is granted and consumes its round-robin slot. It produces rf_we=0 and clears nothing.
- Sources must hold valid, rd and data stable until the transfer. The arbiter never drops a granted request.
- Scoreboard set: iss_valid & !iss_stall & iss_has_rd & iss_rd!=0 sets busy[iss_rd] at the clock edge.
- Scoreboard clear: rf_we=1 clears busy[rf_waddr] at the clock edge. The register file captures the same data at that same edge.
- Simultaneous set and clear of the same register: set wins; the new producer is outstanding.
- busy[0] is constant 0. x0 never stalls issue.
- iss_stall is computed from current busy bits only; there is no same-cycle bypass from the pending rf_we.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, busy_vec=0. src_ready and iss_stall follow combinationally from inputs and reset state.
- Reset takes priority over every grant, set and clear in the same cycle. A request granted in the reset cycle is lost; requesters are reset in the same cycle.
- Latency: grant at cycle T; rf_we high during T+1; register-file contents and busy clear update at the T+1→T+2 edge.
- Throughput: one write per cycle. With all NUM_SRC sources continuously valid, each source is granted exactly once every NUM_SRC cycles.
- Stall release: the first cycle in which iss_stall can drop for register r is the cycle after rf_we=1 with rf_waddr=r.

## Test plan
- Reset: assert rst with all src_valid high -> src_ready grants source 0 combinationally, but after the rst edge rf_we=0, busy_vec=0, rr_ptr=0.
- Round-robin: hold src_valid=3'b111 with rd=5,6,7 and data=A,B,C -> rf_waddr sequence 5,6,7,5,6,7 with rf_we held at 1, one write per cycle.
- Single source: src_valid=3'b100, rd=9, data=0xDEADBEEF -> ready[2] same cycle; next cycle rf_we=1, rf_waddr=9, rf_wdata=0xDEADBEEF.
- Hazard: issue rd=4; next cycle present iss_rs1=4 -> iss_stall=1. Then grant a writeback to rd=4 -> iss_stall stays 1 through the rf_we cycle and drops to 0 the following cycle.
- x0: issue rd=0, then src writeback to rd=0 -> busy_vec stays 0, rf_we stays 0, and rr_ptr still advances past that source.
- Collision: rf_we=1 to rf_waddr=8 in the same cycle as an issue with iss_rd=8 -> busy[8]=1 after the edge.
